mcs4_cycle_gen: RTL and testbench

MCS4_CYCLE_GEN -- requirements
Module: mcs4_cycle_gen

---
 rtl/mcs4_cycle_gen.sv | 124 ++++++++++++
 tb/tb_mcs4_cycle_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mcs4_cycle_gen.sv
// Two-phase non-overlapping clock and 8-subcycle instruction timing generator
// for an MCS-4 style bus, with free-run and single-step control.
module mcs4_cycle_gen #(
  parameter int PW         = 2,
  parameter int GAP        = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  input  logic       step_i,
  output logic       PHI1_o,
  output logic       PHI2_o,
  output logic       SYNC_o,
  output logic [2:0] subcycle_o,
  output logic       cycle_done_o,
  output logic       busy_o
);

  localparam int P  = 2 * (PW + GAP);
  localparam int CW = $clog2(P);

  localparam logic [CW-1:0] C_LAST      = CW'(P - 1);
  localparam logic [CW-1:0] C_PHI1_END  = CW'(PW - 1);
  localparam logic [CW-1:0] C_PHI2_BEG  = CW'(PW + GAP);
  localparam logic [CW-1:0] C_PHI2_END  = CW'(2 * PW + GAP - 1);
  localparam logic [CW-1:0] C_ONE       = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_c;
  logic [CW-1:0] w_c_nxt;
  logic [2:0]    r_sub;
  logic [2:0]    w_sub_nxt;
  logic          w_busy;
  logic          w_phi1;
  logic          w_phi2;
  logic          w_sync;
  logic          w_done;
  logic          r_phi1;
  logic          r_phi2;
  logic          r_sync;
  logic          r_done;
  logic          r_busy;

  // Next state, phase count and subcycle; outputs are decoded from these
  // next values so the pins register in step with the state they describe.
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = '0;
    w_sub_nxt   = 3'd0;
    case (r_state)
      ST_IDLE: begin
        if (run_i) begin
          w_state_nxt = ST_RUN;
        end else if (step_i) begin
          w_state_nxt = ST_STEP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        if (r_c == C_LAST) begin
          w_c_nxt   = '0;
          w_sub_nxt = r_sub + 3'd1;
          if (r_sub == 3'd7) begin
            w_state_nxt = run_i ? ST_RUN : ST_IDLE;
          end else begin
            w_state_nxt = r_state;
          end
        end else begin
          w_c_nxt   = r_c + C_ONE;
          w_sub_nxt = r_sub;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy = (w_state_nxt != ST_IDLE);
    w_phi1 = w_busy && (w_c_nxt <= C_PHI1_END);
    w_phi2 = w_busy && (w_c_nxt >= C_PHI2_BEG) && (w_c_nxt <= C_PHI2_END);
    w_sync = w_busy && (w_sub_nxt == 3'd7);
    w_done = w_busy && (w_sub_nxt == 3'd7) && (w_c_nxt == C_LAST);
  end

  // State and output registers; reset parks every pin at its inactive level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_sub   <= 3'd0;
      r_phi1  <= ACTIVE_LOW;
      r_phi2  <= ACTIVE_LOW;
      r_sync  <= ACTIVE_LOW;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_sub   <= w_sub_nxt;
      r_phi1  <= w_phi1 ^ ACTIVE_LOW;
      r_phi2  <= w_phi2 ^ ACTIVE_LOW;
      r_sync  <= w_sync ^ ACTIVE_LOW;
      r_done  <= w_done;
      r_busy  <= w_busy;
    end
  end

  assign PHI1_o       = r_phi1;
  assign PHI2_o       = r_phi2;
  assign SYNC_o       = r_sync;
  assign subcycle_o   = r_sub;
  assign cycle_done_o = r_done;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_mcs4_cycle_gen.sv
// Scoreboard bench: four parameterisations share the same stimulus and are
// compared every cycle against a position-in-instruction-cycle model.
module tb_mcs4_cycle_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic step = 1'b0;

  always #5 clk = ~clk;

  localparam int PWA  [4] = '{2, 1, 3, 2};
  localparam int GAPA [4] = '{1, 0, 2, 1};
  localparam int ALA  [4] = '{0, 0, 0, 1};

  logic [7:0] act [4];
  logic       phi1 [4];
  logic       phi2 [4];
  logic       sync [4];
  logic [2:0] sub  [4];
  logic       done [4];
  logic       busy [4];

  mcs4_cycle_gen u0 (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .step_i(step),
    .PHI1_o(phi1[0]), .PHI2_o(phi2[0]), .SYNC_o(sync[0]),
    .subcycle_o(sub[0]), .cycle_done_o(done[0]), .busy_o(busy[0]));

  mcs4_cycle_gen #(.PW(1), .GAP(0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .step_i(step),
    .PHI1_o(phi1[1]), .PHI2_o(phi2[1]), .SYNC_o(sync[1]),
    .subcycle_o(sub[1]), .cycle_done_o(done[1]), .busy_o(busy[1]));

  mcs4_cycle_gen #(.PW(3), .GAP(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .step_i(step),
    .PHI1_o(phi1[2]), .PHI2_o(phi2[2]), .SYNC_o(sync[2]),
    .subcycle_o(sub[2]), .cycle_done_o(done[2]), .busy_o(busy[2]));

  mcs4_cycle_gen #(.ACTIVE_LOW(1'b1)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .step_i(step),
    .PHI1_o(phi1[3]), .PHI2_o(phi2[3]), .SYNC_o(sync[3]),
    .subcycle_o(sub[3]), .cycle_done_o(done[3]), .busy_o(busy[3]));

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      act[k] = {phi1[k], phi2[k], sync[k], sub[k], done[k], busy[k]};
    end
  end

  // Model: mode 0=idle 1=run 2=step; pos = clk count inside the instruction cycle.
  int mode [4];
  int pos  [4];
  logic [31:0] q [$];
  logic [31:0] e_all;
  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] expect_vec(input int k, input int md, input int ps);
    int  p;
    int  c;
    int  s;
    logic b;
    logic a;
    p = 2 * (PWA[k] + GAPA[k]);
    c = ps % p;
    s = ps / p;
    b = (md != 0);
    a = (ALA[k] != 0);
    return {(b && c < PWA[k]) ^ a,
            (b && c >= PWA[k] + GAPA[k] && c < 2 * PWA[k] + GAPA[k]) ^ a,
            (b && s == 7) ^ a,
            3'(s),
            b && (ps == 8 * p - 1),
            b};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        mode[k] = 0;
        pos[k]  = 0;
      end else if (mode[k] == 0) begin
        pos[k] = 0;
        if (run) mode[k] = 1;
        else if (step) mode[k] = 2;
      end else if (pos[k] == 16 * (PWA[k] + GAPA[k]) - 1) begin
        pos[k]  = 0;
        mode[k] = run ? 1 : 0;
      end else begin
        pos[k] = pos[k] + 1;
      end
      e_all[8*k +: 8] = expect_vec(k, mode[k], pos[k]);
    end
    q.push_back(e_all);
  end

  // An asynchronous reset between edges overrides the expectation already queued.
  always @(negedge rst_n) begin
    for (int k = 0; k < 4; k++) begin
      mode[k] = 0;
      pos[k]  = 0;
      e_all[8*k +: 8] = expect_vec(k, 0, 0);
    end
    if (q.size() > 0) begin
      void'(q.pop_back());
      q.push_back(e_all);
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_v;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_underflow t=%0t actual=empty required=entry", $time);
    end else begin
      exp_v = q.pop_front();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (act[k] !== exp_v[8*k +: 8]) begin
          failures++;
          if (failures < 20)
            $display("FAIL outputs_u%0d t=%0t actual=%b required=%b (phi1 phi2 sync sub3 done busy)",
                     k, $time, act[k], exp_v[8*k +: 8]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    // free run, then drop run mid instruction cycle
    run = 1'b1;
    cyc(116);
    run = 1'b0;
    cyc(100);
    // single step with an ignored second pulse inside it
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(10);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(100);
    // step held high: back-to-back steps through IDLE
    step = 1'b1;
    cyc(200);
    step = 1'b0;
    cyc(100);
    // reset in the middle of a run, run still high on release
    run = 1'b1;
    cyc(30);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(60);
    run = 1'b0;
    cyc(100);
    // randomized control
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) run = ~run;
      step = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        cyc($urandom_range(1, 2));
        rst_n = 1'b1;
      end else begin
        cyc(1);
      end
    end
    run = 1'b0;
    step = 1'b0;
    cyc(2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
